if_id_reg: RTL and testbench
============================

IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low, released synchronously to clk.
REQ-003 SHALL have port if_valid  input  1  fetch stage presents a valid instruction this cycle.
REQ-004 SHALL have port if_pc  input  32  PC+4 of the fetched instruction.
REQ-005 SHALL have port if_instr  input  32  fetched instruction word.
REQ-006 SHALL have port stall  input  1  hold the current register contents.
REQ-007 SHALL have port flush  input  1  replace the register contents with a bubble.
REQ-008 SHALL have port id_valid  output  1  decode stage holds a valid instruction.
REQ-009 SHALL have port id_pc  output  32  registered PC+4.
REQ-010 SHALL have port id_instr  output  32  registered instruction word.
REQ-011 SHALL have ports id_opcode, id_rs, id_rt, id_rd, id_shamt, id_funct  output  6/5/5/5/5/6  fields taken from id_instr[31:26], [25:21], [20:16], [15:11], [10:6], [5:0].
REQ-012 SHALL have port id_imm16  output  16  id_instr[15:0]; feeds the immediate extender input.
REQ-013 SHALL have port id_extop  output  1  immediate-extension select for the extender (1 = sign, 0 = zero).
REQ-014 SHALL have port id_stall_cnt  output  16  stall statistic; present only when IFID_PERF_CNT_EN is defined.

Function
REQ-015 SHALL update id_valid, id_pc and id_instr on each rising clk edge, with priority flush > stall > load.
REQ-016 SHALL, on flush, set id_valid=0, id_instr=32'h0000_0000 (NOP) and id_pc=0, regardless of the stall input.
REQ-017 SHALL, on stall without flush, hold id_valid, id_pc and id_instr unchanged.
REQ-018 SHALL, on load, capture id_valid=if_valid, id_pc=if_pc and id_instr=(if_valid ? if_instr : 0).
REQ-019 SHALL have a latency of exactly one cycle from the if_* inputs to the id_* outputs.
REQ-020 SHALL derive all field outputs and id_extop combinationally from the registered id_instr only.
REQ-021 SHALL drive id_extop=1 for opcodes 0x04, 0x05, 0x08, 0x09, 0x0A, 0x0B, 0x20, 0x21, 0x23, 0x24, 0x25, 0x28, 0x29 and 0x2B.
REQ-022 SHALL drive id_extop=0 for opcodes 0x0C, 0x0D, 0x0E and 0x0F, for R-type (0x00), and for all other opcodes.
REQ-023 SHALL force id_extop=0 whenever id_valid=0.

Reset
REQ-024 SHALL, while rst_n=0, hold id_valid=0, id_pc=0 and id_instr=0, which gives all field outputs and id_extop the value 0.
REQ-025 SHALL let a reset asserted mid-stall or mid-flush override both immediately, without waiting for a clock edge.
REQ-026 SHALL perform its first load on the first rising clk edge after rst_n is released.

Configuration
REQ-027 SHALL implement the stall counter only when the macro IFID_PERF_CNT_EN is defined.
REQ-028 SHALL, with IFID_PERF_CNT_EN defined, increment id_stall_cnt on every edge where stall=1 and flush=0.
REQ-029 SHALL saturate id_stall_cnt at 16'hFFFF, reset it to 0 on rst_n=0, and leave it unaffected by flush.
REQ-030 SHALL, without IFID_PERF_CNT_EN, omit both the id_stall_cnt port and its logic, leaving all other behaviour identical.

Verification
REQ-031 SHALL cover the load case: if_valid=1, if_instr=32'h2008FFFF (addi) -> next cycle id_valid=1, id_imm16=16'hFFFF, id_extop=1, id_rt=8.
REQ-032 SHALL cover the zero-extend case: if_instr=32'h3508_8000 (ori) -> id_extop=0 and id_imm16=16'h8000.
REQ-033 SHALL cover a 3-cycle stall while the if_* inputs change -> id_* outputs unchanged; with IFID_PERF_CNT_EN defined, id_stall_cnt increases by 3.
REQ-034 SHALL cover stall=1 together with flush=1 -> next cycle id_valid=0, id_instr=0, id_extop=0, and id_stall_cnt not incremented.
REQ-035 SHALL cover rst_n asserted between clock edges while holding a valid instruction -> outputs clear immediately, and the first edge after release loads the if_* inputs.
REQ-036 SHALL cover counter saturation: preload to 16'hFFFE, apply 3 stall cycles -> id_stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with instruction field decode and immediate-extension select.
// Optional stall statistic counter enabled by defining IFID_PERF_CNT_EN.
module if_id_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instr,
    input  logic        stall,
    input  logic        flush,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [5:0]  id_opcode,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [4:0]  id_shamt,
    output logic [5:0]  id_funct,
    output logic [15:0] id_imm16,
`ifdef IFID_PERF_CNT_EN
    output logic        id_extop,
    output logic [15:0] id_stall_cnt
`else
    output logic        id_extop
`endif
);

    logic        valid_reg;
    logic [31:0] pc_reg;
    logic [31:0] instr_reg;

    // Flush outranks stall so a squashed instruction never lingers in decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            pc_reg    <= 32'h0;
            instr_reg <= 32'h0;
        end else if (flush) begin
            valid_reg <= 1'b0;
            pc_reg    <= 32'h0;
            instr_reg <= 32'h0;
        end else if (!stall) begin
            valid_reg <= if_valid;
            pc_reg    <= if_pc;
            instr_reg <= if_valid ? if_instr : 32'h0;
        end
    end

    assign id_valid  = valid_reg;
    assign id_pc     = pc_reg;
    assign id_instr  = instr_reg;
    assign id_opcode = instr_reg[31:26];
    assign id_rs     = instr_reg[25:21];
    assign id_rt     = instr_reg[20:16];
    assign id_rd     = instr_reg[15:11];
    assign id_shamt  = instr_reg[10:6];
    assign id_funct  = instr_reg[5:0];
    assign id_imm16  = instr_reg[15:0];

    logic sign_op;

    // Branches, arithmetic immediates and loads/stores sign-extend; logical immediates do not.
    always_comb begin
        sign_op = 1'b0;
        case (instr_reg[31:26])
            6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
            6'h28, 6'h29, 6'h2B: sign_op = 1'b1;
            default:             sign_op = 1'b0;
        endcase
    end

    assign id_extop = valid_reg & sign_op;

`ifdef IFID_PERF_CNT_EN
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= 16'h0;
        end else if (stall && !flush && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'h1;
        end
    end

    assign id_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// Self-checking bench for if_id_reg: spec-level model compared every cycle plus directed literal checks.
// Build with IFID_PERF_CNT_EN defined to also exercise the stall counter.
module tb_if_id_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [4:0]  id_shamt;
    logic [5:0]  id_funct;
    logic [15:0] id_imm16;
    logic        id_extop;
`ifdef IFID_PERF_CNT_EN
    logic [15:0] id_stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    if_id_reg dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_shamt(id_shamt), .id_funct(id_funct), .id_imm16(id_imm16),
`ifdef IFID_PERF_CNT_EN
        .id_extop(id_extop), .id_stall_cnt(id_stall_cnt)
`else
        .id_extop(id_extop)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level model: decode contents as a tuple, counter as a saturating tally.
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    int          m_cnt;

    function automatic bit sign_ext_op(input logic [5:0] op);
        logic [5:0] ops [14] = '{6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h20,
                                 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
        foreach (ops[i]) if (ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_pc    <= 32'h0;
            m_instr <= 32'h0;
            m_cnt   <= 0;
        end else begin
            if (flush) begin
                m_valid <= 1'b0;
                m_pc    <= 32'h0;
                m_instr <= 32'h0;
            end else if (!stall) begin
                m_valid <= if_valid;
                m_pc    <= if_pc;
                m_instr <= if_valid ? if_instr : 32'h0;
            end
            if (stall && !flush) m_cnt <= (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        chk("cyc_valid", {31'h0, id_valid}, {31'h0, m_valid});
        chk("cyc_pc", id_pc, m_pc);
        chk("cyc_instr", id_instr, m_instr);
        chk("cyc_fields", {id_opcode, id_rs, id_rt, id_rd, id_shamt, id_funct}, m_instr);
        chk("cyc_imm16", {16'h0, id_imm16}, {16'h0, m_instr[15:0]});
        chk("cyc_extop", {31'h0, id_extop}, {31'h0, m_valid & sign_ext_op(m_instr[31:26])});
`ifdef IFID_PERF_CNT_EN
        chk("cyc_stall_cnt", {16'h0, id_stall_cnt}, m_cnt);
`endif
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic st, input logic fl);
        if_valid = v; if_pc = pc; if_instr = ins; stall = st; flush = fl;
    endtask

    logic [31:0] opc_tbl [6] = '{32'h0109_5020, 32'h3108_00FF, 32'h3C08_1234,
                                 32'hAD09_FFFC, 32'hFC00_8001, 32'h1500_FFFE};
    logic        ext_tbl [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 32'h44, 32'h2008_FFFF, 1'b0, 1'b0);
        cyc(); cyc();
        chk("reset_valid", {31'h0, id_valid}, 32'h0);
        chk("reset_instr", id_instr, 32'h0);
        chk("reset_extop", {31'h0, id_extop}, 32'h0);

        rst_n = 1'b1;
        drive(1'b1, 32'h4, 32'h2008_FFFF, 1'b0, 1'b0);
        cyc();
        $display("load addi: valid=%0b imm=%h extop=%0b rt=%0d", id_valid, id_imm16, id_extop, id_rt);
        chk("addi_valid", {31'h0, id_valid}, 32'h1);
        chk("addi_imm16", {16'h0, id_imm16}, 32'hFFFF);
        chk("addi_extop", {31'h0, id_extop}, 32'h1);
        chk("addi_rt", {27'h0, id_rt}, 32'd8);
        chk("addi_pc", id_pc, 32'h4);

        drive(1'b1, 32'h8, 32'h3508_8000, 1'b0, 1'b0);
        cyc();
        $display("load ori: extop=%0b imm=%h", id_extop, id_imm16);
        chk("ori_extop", {31'h0, id_extop}, 32'h0);
        chk("ori_imm16", {16'h0, id_imm16}, 32'h8000);

        drive(1'b0, 32'hC, 32'h2008_FFFF, 1'b0, 1'b0);
        cyc();
        $display("load invalid: valid=%0b instr=%h", id_valid, id_instr);
        chk("inv_instr", id_instr, 32'h0);
        chk("inv_extop", {31'h0, id_extop}, 32'h0);

        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h100 + 4 * i, opc_tbl[i], 1'b0, 1'b0);
            cyc();
            $display("opcode %h: extop=%0b", id_opcode, id_extop);
            chk("tbl_extop", {31'h0, id_extop}, {31'h0, ext_tbl[i]});
        end

        drive(1'b1, 32'h10, 32'h1000_0003, 1'b0, 1'b0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h200 + i, 32'h8C00_0000 + i, 1'b1, 1'b0);
            cyc();
            $display("stall %0d: pc=%h instr=%h", i, id_pc, id_instr);
            chk("stall_pc", id_pc, 32'h10);
            chk("stall_instr", id_instr, 32'h1000_0003);
            chk("stall_valid", {31'h0, id_valid}, 32'h1);
        end
`ifdef IFID_PERF_CNT_EN
        chk("stall_cnt3", {16'h0, id_stall_cnt}, 32'd3);
`endif

        drive(1'b1, 32'h300, 32'h2008_0001, 1'b1, 1'b1);
        cyc();
        $display("stall+flush: valid=%0b instr=%h", id_valid, id_instr);
        chk("flush_valid", {31'h0, id_valid}, 32'h0);
        chk("flush_instr", id_instr, 32'h0);
        chk("flush_pc", id_pc, 32'h0);
        chk("flush_extop", {31'h0, id_extop}, 32'h0);
`ifdef IFID_PERF_CNT_EN
        chk("flush_cnt", {16'h0, id_stall_cnt}, 32'd3);
`endif

        drive(1'b1, 32'h40, 32'h8D09_0010, 1'b0, 1'b0);
        cyc();
        chk("lw_valid", {31'h0, id_valid}, 32'h1);
        drive(1'b1, 32'h44, 32'h2108_0005, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        $display("async reset: valid=%0b instr=%h", id_valid, id_instr);
        chk("arst_valid", {31'h0, id_valid}, 32'h0);
        chk("arst_instr", id_instr, 32'h0);
        chk("arst_extop", {31'h0, id_extop}, 32'h0);
        cyc();
        rst_n = 1'b1;
        drive(1'b1, 32'h48, 32'h2108_0005, 1'b0, 1'b0);
        cyc();
        $display("post-reset load: pc=%h instr=%h", id_pc, id_instr);
        chk("rel_pc", id_pc, 32'h48);
        chk("rel_instr", id_instr, 32'h2108_0005);
        chk("rel_extop", {31'h0, id_extop}, 32'h1);

`ifdef IFID_PERF_CNT_EN
        chk("rel_cnt", {16'h0, id_stall_cnt}, 32'h0);
        drive(1'b1, 32'h50, 32'h0, 1'b1, 1'b0);
        repeat (65534) cyc();
        chk("pre_cnt", {16'h0, id_stall_cnt}, 32'hFFFE);
        repeat (3) cyc();
        $display("saturation: cnt=%h", id_stall_cnt);
        chk("sat_cnt", {16'h0, id_stall_cnt}, 32'hFFFF);
`endif

        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
